reg_check_seq: RTL

Synthesizable, parametrised self-check sequencer for the rv32i core. After `start`, it counts core clock cycles and compares architectural registers against up to `NUM_CHECKS` scheduled expectations. Each expectation is (cycle, register index, expected value, mask). The block sits beside `top`, reads the register file through a dedicated combinational probe port, and reports pass/fail/done, so directed program tests and on-board smoke tests share one checker.

---
 rtl/reg_check_seq_pkg.sv | 30 +++
 rtl/sat_counter.sv | 37 +++
 rtl/reg_check_seq.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/reg_check_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_check_seq_pkg
// Description : Shared types and helpers for the register self-check
//               sequencer: the sequencer state encoding and a masked
//               equality compare.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_check_seq_pkg;

  // Widest data word the masked compare accepts. Callers size-cast their
  // XLEN-wide operands up to this width, so XLEN must not exceed it.
  localparam int MASK_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } chk_state_e;

  // True when a and b agree on every bit selected by m.
  function automatic logic masked_eq(input logic [MASK_W-1:0] a,
                                     input logic [MASK_W-1:0] b,
                                     input logic [MASK_W-1:0] m);
    return ((a ^ b) & m) == '0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up counter that stops at all-ones. It is shared by the
//               register check sequencer and the core performance counters.
// Ports       : clk, rst (async, active-high)
//               clr - synchronous clear to 0 (wins over en)
//               en  - count enable
//               q   - current count
//               max - q is all-ones (saturated)
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q,
  output logic         max
);

  assign max = &q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en && !max) begin
      q <= q + W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/reg_check_seq.sv
`default_nettype none
// ============================================================================
// Module      : reg_check_seq
// Description : Self-check sequencer. After start, it counts RUN cycles and
//               compares architectural registers, read through a
//               combinational probe port, against a table of
//               (cycle, reg, value, mask) checkpoints. It reports
//               pass/fail/timeout.
// Ports       : clk, rst (async, active-high)
//               start             - arms a run when not busy
//               num_checks        - checkpoints in use, sampled at start
//               chk_cycle/reg/val/mask - flattened checkpoint table (live)
//               probe_addr/data   - register file probe (async read)
//               busy, pass, fail, fail_idx, fail_got, timeout - status
// Revision    : 1.0 - initial release
// ============================================================================
module reg_check_seq
  import reg_check_seq_pkg::*;
#(
  parameter  int XLEN       = 32,
  parameter  int NUM_REGS   = 32,
  parameter  int NUM_CHECKS = 8,   // must be at least 2
  parameter  int CYCLE_W    = 16,
  localparam int RIDX_W     = $clog2(NUM_REGS),
  localparam int CIDX_W     = $clog2(NUM_CHECKS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [CIDX_W:0]            num_checks,
  input  logic [NUM_CHECKS*CYCLE_W-1:0] chk_cycle,
  input  logic [NUM_CHECKS*RIDX_W-1:0]  chk_reg,
  input  logic [NUM_CHECKS*XLEN-1:0]    chk_val,
  input  logic [NUM_CHECKS*XLEN-1:0]    chk_mask,
  output logic [RIDX_W-1:0]          probe_addr,
  input  logic [XLEN-1:0]            probe_data,
  output logic                       busy,
  output logic                       pass,
  output logic                       fail,
  output logic [CIDX_W-1:0]          fail_idx,
  output logic [XLEN-1:0]            fail_got,
  output logic                       timeout
);

  chk_state_e          r_state;
  logic [CIDX_W-1:0]   r_idx;
  logic [CIDX_W:0]     r_num;

  logic [CYCLE_W-1:0]  w_cnt;
  logic                w_cnt_max;
  logic                w_start;
  logic [CYCLE_W-1:0]  w_due;
  logic [XLEN-1:0]     w_val;
  logic [XLEN-1:0]     w_mask;
  logic                w_fire;
  logic                w_match;
  logic                w_last;

  // A new run may be armed from any state except RUN.
  assign w_start = start && (r_state != ST_RUN);

  sat_counter #(.W(CYCLE_W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (w_start),
    .en  (r_state == ST_RUN),
    .q   (w_cnt),
    .max (w_cnt_max)
  );

  // The table is read live at the current checkpoint index.
  assign w_due      = chk_cycle[int'(r_idx)*CYCLE_W +: CYCLE_W];
  assign probe_addr = chk_reg[int'(r_idx)*RIDX_W +: RIDX_W];
  assign w_val      = chk_val[int'(r_idx)*XLEN +: XLEN];
  assign w_mask     = chk_mask[int'(r_idx)*XLEN +: XLEN];

  // The >= compare lets checkpoints that are late (equal or out-of-order due
  // cycles) fire back to back, one per cycle.
  assign w_fire  = (r_state == ST_RUN) && (w_cnt >= w_due);
  assign w_match = masked_eq(MASK_W'(probe_data), MASK_W'(w_val), MASK_W'(w_mask));
  assign w_last  = ({1'b0, r_idx} == (r_num - 1'b1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_num    <= '0;
      busy     <= 1'b0;
      pass     <= 1'b0;
      fail     <= 1'b0;
      fail_idx <= '0;
      fail_got <= '0;
      timeout  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_PASS, ST_FAIL: begin
          if (start) begin
            r_idx    <= '0;
            r_num    <= num_checks;
            fail     <= 1'b0;
            fail_idx <= '0;
            fail_got <= '0;
            timeout  <= 1'b0;
            if (num_checks == '0) begin
              r_state <= ST_PASS;
              pass    <= 1'b1;
            end else begin
              r_state <= ST_RUN;
              pass    <= 1'b0;
              busy    <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          // A check that fires wins over saturation. If it matches but is
          // not the last one, the run still times out on the saturated
          // cycle, and the checkpoint that was current is reported.
          if (w_fire && !w_match) begin
            r_state  <= ST_FAIL;
            busy     <= 1'b0;
            fail     <= 1'b1;
            fail_idx <= r_idx;
            fail_got <= probe_data;
          end else if (w_fire && w_last) begin
            r_state <= ST_PASS;
            busy    <= 1'b0;
            pass    <= 1'b1;
          end else if (w_cnt_max) begin
            r_state  <= ST_FAIL;
            busy     <= 1'b0;
            fail     <= 1'b1;
            timeout  <= 1'b1;
            fail_idx <= r_idx;
          end else if (w_fire) begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
